// File: rtl/sst_dump_seq.sv
`default_nettype none
// ============================================================================
// Module   : sst_dump_seq
// Purpose  : Walks a window of the 8 KB SST space through the registered read
//            path and streams the bytes out over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module sst_dump_seq #(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [12:0] base_addr,
    input  logic [13:0] len,
    output logic [12:0] sst_addr,
    output logic        sst_ce,
    input  logic [7:0]  sst_di,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [12:0]       addr_q, addr_d;
    logic [13:0]       rem_q, rem_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic w_push;
    logic w_pop;
    logic w_flush;
    logic w_issue;
    logic w_credit_ok;
    int   w_inflight;

    assign sst_addr  = addr_q;
    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign sst_ce    = busy;
    assign done      = (state_q == S_DONE);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rptr_q];

    assign w_push  = pipe_q[RD_LAT-1];
    assign w_pop   = out_valid & out_ready;
    assign w_flush = abort && busy;

    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + int'(pipe_q[i]);
        end
    end

    // Reads already in the pipe reserve a FIFO slot, so the FIFO can never
    // overflow and sst_di never needs to stall.
    assign w_credit_ok = (int'(count_q) + w_inflight) < FIFO_DEPTH;
    assign w_issue     = (state_q == S_ISSUE) && !abort && w_credit_ok && (rem_q != '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        pipe_d[0] = w_issue;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (w_push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (w_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CW'(1);
        end

        if (w_issue) begin
            addr_d = addr_q + 13'd1;
            rem_d  = rem_q - 14'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    addr_d  = base_addr;
                    rem_d   = (len == 14'd0) ? 14'd8192 : len;
                end
            end
            S_ISSUE: begin
                if (w_issue && (rem_q == 14'd1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Enter DONE on the edge that accepts the final byte.
                if ((count_d == '0) && (pipe_d == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_flush) begin
            state_d = S_IDLE;
            pipe_d  = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pipe_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pipe_q  <= pipe_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_push && !w_flush) begin
            mem_q[wptr_q] <= sst_di;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sst_dump_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sst_dump_seq
// Purpose  : Directed self-checking bench for the SST dump sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sst_dump_seq;

    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic        abort;
    logic [12:0] base_addr;
    logic [13:0] len;
    logic [12:0] sst_addr;
    logic        sst_ce;
    logic [7:0]  sst_di;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [7:0]  d1_q;
    logic [7:0]  rx_q [$];
    logic [12:0] trace_q [$];

    int errors = 0;
    int checks = 0;

    sst_dump_seq #(
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .len       (len),
        .sst_addr  (sst_addr),
        .sst_ce    (sst_ce),
        .sst_di    (sst_di),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sst_byte(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]};
    endfunction

    // Two-register SST read path: data appears RD_LAT clocks after the address.
    always @(posedge clk) begin
        d1_q   <= sst_byte(sst_addr);
        sst_di <= d1_q;
    end

    task automatic do_start(input logic [12:0] b, input logic [13:0] l);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Stream collector: mode 0 ready high, 1 random ready, 2 ready low 20 clk.
    task automatic collect(input int n, input int mode, input int max_cyc,
                           output int first_valid, output int done_cnt,
                           output int done_gap, output int incs, output int max_out);
        int          idx;
        int          acc;
        int          last_acc;
        int          done_idx;
        logic        prev_ce;
        logic [12:0] prev_addr;
        rx_q.delete();
        trace_q.delete();
        idx = 0; acc = 0; last_acc = 0; done_idx = -100;
        first_valid = -1; done_cnt = 0; incs = 0; max_out = 0;
        prev_ce = 1'b0; prev_addr = '0;
        while (idx < max_cyc) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1, 0));
                default: out_ready = (idx >= 20);
            endcase
            if (sst_ce) begin
                if (prev_ce && (sst_addr != prev_addr)) incs++;
                if (trace_q.size() == 0 || trace_q[$] != sst_addr) trace_q.push_back(sst_addr);
            end
            prev_ce   = sst_ce;
            prev_addr = sst_addr;
            if ((incs - acc) > max_out) max_out = incs - acc;
            if (out_valid && first_valid < 0) first_valid = idx;
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                last_acc = idx;
                acc++;
            end
            if (done) begin
                done_cnt++;
                done_idx = idx;
            end
            if (acc == n && idx >= last_acc + 4) break;
            @(negedge clk);
            idx++;
        end
        done_gap = done_idx - last_acc;
    endtask

    function automatic int data_mism(input logic [12:0] b, input int n);
        int m = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= rx_q.size()) m++;
            else if (rx_q[i] !== sst_byte(b + 13'(i))) m++;
        end
        return m;
    endfunction

    function automatic int trace_mism(input logic [12:0] b, input int n);
        int m = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= trace_q.size()) m++;
            else if (trace_q[i] !== b + 13'(i)) m++;
        end
        return m;
    endfunction

    task automatic test_reset;
        sys_rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_addr = '0; len = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sst_addr, sst_ce, out_data, out_valid, busy, done} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h ce=%b data=%h valid=%b busy=%b done=%b, want all 0",
                     sst_addr, sst_ce, out_data, out_valid, busy, done);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic;
        int fv, dc, dg, inc, mo, m;
        out_ready = 1'b1;
        do_start(13'h000, 14'd4);
        collect(4, 0, 200, fv, dc, dg, inc, mo);
        checks++;
        if (fv !== RD_LAT + 1) begin
            errors++; $display("FAIL basic_latency: got %0d clk, want %0d", fv, RD_LAT + 1);
        end
        m = trace_mism(13'h000, 4);
        checks++;
        if (m !== 0) begin
            errors++; $display("FAIL basic_addrs: got %0d bad addresses, want 0", m);
        end
        checks++;
        if (rx_q.size() !== 4) begin
            errors++; $display("FAIL basic_count: got %0d bytes, want 4", rx_q.size());
        end
        m = data_mism(13'h000, 4);
        checks++;
        if (m !== 0) begin
            errors++; $display("FAIL basic_data: got %0d bad bytes, want 0", m);
        end
        checks++;
        if (dc !== 1 || dg !== 1) begin
            errors++; $display("FAIL basic_done: got %0d pulses gap %0d, want 1 pulse gap 1", dc, dg);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL basic_busy_after: got %b, want 0", busy);
        end
    endtask

    task automatic test_wrap;
        int fv, dc, dg, inc, mo, m, md;
        out_ready = 1'b1;
        do_start(13'h1FFE, 14'd4);
        collect(4, 0, 200, fv, dc, dg, inc, mo);
        m  = trace_mism(13'h1FFE, 4);
        md = data_mism(13'h1FFE, 4);
        checks++;
        if (m !== 0 || md !== 0 || rx_q.size() !== 4) begin
            errors++;
            $display("FAIL wrap_stream: got %0d bad addrs %0d bad bytes %0d bytes, want 0 0 4",
                     m, md, rx_q.size());
        end
        checks++;
        if (dc !== 1) begin
            errors++; $display("FAIL wrap_done: got %0d pulses, want 1", dc);
        end
    endtask

    task automatic test_backpressure;
        int fv, dc, dg, inc, mo, m;
        do_start(13'h0200, 14'd16);
        collect(16, 2, 400, fv, dc, dg, inc, mo);
        checks++;
        if (mo !== FIFO_DEPTH) begin
            errors++; $display("FAIL bp_outstanding: got max %0d, want %0d", mo, FIFO_DEPTH);
        end
        checks++;
        if (inc !== 16) begin
            errors++; $display("FAIL bp_issues: got %0d, want 16", inc);
        end
        m = data_mism(13'h0200, 16);
        checks++;
        if (m !== 0 || rx_q.size() !== 16) begin
            errors++; $display("FAIL bp_data: got %0d bad bytes, %0d bytes, want 0 and 16", m, rx_q.size());
        end
        checks++;
        if (dc !== 1) begin
            errors++; $display("FAIL bp_done: got %0d pulses, want 1", dc);
        end
    endtask

    task automatic test_abort;
        int acc, cyc, mism, dn, bad;
        int fv, dc, dg, inc, mo, m;
        out_ready = 1'b1;
        do_start(13'h0100, 14'd32);
        acc = 0; cyc = 0; mism = 0; dn = 0; bad = 0;
        while (acc < 5 && cyc < 50) begin
            if (out_valid && out_ready) begin
                if (out_data !== sst_byte(13'h0100 + 13'(acc))) mism++;
                acc++;
            end
            if (done) dn++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (acc !== 5 || mism !== 0) begin
            errors++; $display("FAIL abort_prefix: got %0d accepts %0d bad, want 5 0", acc, mism);
        end
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sst_ce !== 1'b0) begin
            errors++;
            $display("FAIL abort_next_clk: got valid=%b busy=%b ce=%b, want 0 0 0", out_valid, busy, sst_ce);
        end
        for (int i = 0; i < 8; i++) begin
            if (done) dn++;
            if (out_valid || busy) bad++;
            @(negedge clk);
        end
        checks++;
        if (dn !== 0 || bad !== 0) begin
            errors++; $display("FAIL abort_quiet: got %0d done %0d active cycles, want 0 0", dn, bad);
        end
        out_ready = 1'b1;
        do_start(13'h00A0, 14'd3);
        collect(3, 0, 200, fv, dc, dg, inc, mo);
        m = data_mism(13'h00A0, 3);
        checks++;
        if (m !== 0 || rx_q.size() !== 3 || dc !== 1) begin
            errors++;
            $display("FAIL abort_restart: got %0d bad %0d bytes %0d done, want 0 3 1", m, rx_q.size(), dc);
        end
    endtask

    task automatic test_async_reset;
        int dn;
        out_ready = 1'b1;
        do_start(13'h0040, 14'd100);
        @(negedge clk);
        start = 1'b1; base_addr = 13'h0500; len = 14'd5;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (sst_addr !== 13'h0042 || busy !== 1'b1) begin
            errors++; $display("FAIL busy_start_ignored: got addr=%h busy=%b, want 0042 1", sst_addr, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_pre_valid: got %b, want 1", out_valid);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({sst_addr, sst_ce, out_data, out_valid, busy, done} !== 31'd0) begin
            errors++;
            $display("FAIL async_reset: got addr=%h ce=%b data=%h valid=%b busy=%b done=%b, want all 0",
                     sst_addr, sst_ce, out_data, out_valid, busy, done);
        end
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy || out_valid) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn !== 0) begin
            errors++; $display("FAIL post_reset_idle: got %0d active cycles, want 0", dn);
        end
    endtask

    task automatic test_full_len;
        int fv, dc, dg, inc, mo, m;
        do_start(13'h0123, 14'd0);
        collect(8192, 1, 40000, fv, dc, dg, inc, mo);
        m = data_mism(13'h0123, 8192);
        checks++;
        if (rx_q.size() !== 8192 || m !== 0) begin
            errors++; $display("FAIL full_data: got %0d bytes %0d bad, want 8192 0", rx_q.size(), m);
        end
        checks++;
        if (inc !== 8192 || dc !== 1) begin
            errors++; $display("FAIL full_issue_done: got %0d issues %0d done, want 8192 1", inc, dc);
        end
        checks++;
        if (trace_q.size() < 8192 || trace_q[8191] !== 13'h0122) begin
            errors++;
            $display("FAIL full_last_addr: got %0d trace entries, want last issued 0122", trace_q.size());
        end
        checks++;
        if (mo > FIFO_DEPTH) begin
            errors++; $display("FAIL full_outstanding: got %0d, want <= %0d", mo, FIFO_DEPTH);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_full_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
